// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register feeding the ALU.
// Holds the decoded instruction, selects the ALU operands, detects
// load-use hazards and honours stall/flush from the hazard logic.
// Optional feature macro: ID_EX_FORWARDING_EN adds the EX/MEM and MEM/WB
// forwarding muxes and the refresh of held data while stalled.
module id_ex_stage #(
  parameter int         DATA_WIDTH  = 32,
  parameter int         ADDR_WIDTH  = 5,
  parameter logic [3:0] NOP_CONTROL = 4'b1111
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_control,
  input  logic [ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [ADDR_WIDTH-1:0] in_rt_addr,
  input  logic [ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_use_imm,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  fwd_exmem_valid,
  input  logic [ADDR_WIDTH-1:0] fwd_exmem_addr,
  input  logic [DATA_WIDTH-1:0] fwd_exmem_data,
  input  logic                  fwd_memwb_valid,
  input  logic [ADDR_WIDTH-1:0] fwd_memwb_addr,
  input  logic [DATA_WIDTH-1:0] fwd_memwb_data,
  output logic                  out_valid,
  output logic [3:0]            control,
  output logic [DATA_WIDTH-1:0] operand0,
  output logic [DATA_WIDTH-1:0] operand1,
  output logic [ADDR_WIDTH-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic                  out_mem_read
);

  logic                  held_valid;
  logic [3:0]            held_control;
  logic [ADDR_WIDTH-1:0] held_rs_addr;
  logic [ADDR_WIDTH-1:0] held_rt_addr;
  logic [ADDR_WIDTH-1:0] held_rd_addr;
  logic [DATA_WIDTH-1:0] held_rs_data;
  logic [DATA_WIDTH-1:0] held_rt_data;
  logic [DATA_WIDTH-1:0] held_imm;
  logic                  held_use_imm;
  logic                  held_reg_write;
  logic                  held_mem_read;

  logic [DATA_WIDTH-1:0] fwd_rs;
  logic [DATA_WIDTH-1:0] fwd_rt;
  logic                  hazard;
  logic                  load_bubble;

  // A held load whose destination is read by the incoming instruction
  // cannot supply its data in time, so the incoming one waits a cycle.
  assign hazard = held_valid && held_mem_read && (held_rd_addr != '0) && in_valid &&
                  ((in_rs_addr == held_rd_addr) ||
                   (!in_use_imm && (in_rt_addr == held_rd_addr)));

  assign in_ready = !stall && !flush && !hazard;

`ifdef ID_EX_FORWARDING_EN
  // Pick the youngest in-flight result for each source; register 0 never forwards.
  always_comb begin
    fwd_rs = held_rs_data;
    fwd_rt = held_rt_data;
    if (held_rs_addr != '0) begin
      if (fwd_exmem_valid && (fwd_exmem_addr == held_rs_addr)) begin
        fwd_rs = fwd_exmem_data;
      end else if (fwd_memwb_valid && (fwd_memwb_addr == held_rs_addr)) begin
        fwd_rs = fwd_memwb_data;
      end
    end
    if (held_rt_addr != '0) begin
      if (fwd_exmem_valid && (fwd_exmem_addr == held_rt_addr)) begin
        fwd_rt = fwd_exmem_data;
      end else if (fwd_memwb_valid && (fwd_memwb_addr == held_rt_addr)) begin
        fwd_rt = fwd_memwb_data;
      end
    end
  end
`else
  // Without forwarding the held register-file data goes straight through.
  always_comb begin
    fwd_rs = held_rs_data;
    fwd_rt = held_rt_data;
  end

  logic unused_fwd;
  assign unused_fwd = ^{fwd_exmem_valid, fwd_exmem_addr, fwd_exmem_data,
                        fwd_memwb_valid, fwd_memwb_addr, fwd_memwb_data,
                        held_rs_addr, held_rt_addr};
`endif

  assign load_bubble = reset || flush || (!stall && (hazard || !in_valid));

  // Stage register: bubble on reset/flush/hazard/idle, refresh data on stall, else capture.
  always_ff @(posedge clock) begin
    if (load_bubble) begin
      held_valid     <= 1'b0;
      held_control   <= NOP_CONTROL;
      held_rs_addr   <= '0;
      held_rt_addr   <= '0;
      held_rd_addr   <= '0;
      held_rs_data   <= '0;
      held_rt_data   <= '0;
      held_imm       <= '0;
      held_use_imm   <= 1'b0;
      held_reg_write <= 1'b0;
      held_mem_read  <= 1'b0;
    end else if (stall) begin
      held_rs_data   <= fwd_rs;
      held_rt_data   <= fwd_rt;
    end else begin
      held_valid     <= 1'b1;
      held_control   <= in_control;
      held_rs_addr   <= in_rs_addr;
      held_rt_addr   <= in_rt_addr;
      held_rd_addr   <= in_rd_addr;
      held_rs_data   <= in_rs_data;
      held_rt_data   <= in_rt_data;
      held_imm       <= in_imm;
      held_use_imm   <= in_use_imm;
      held_reg_write <= in_reg_write;
      held_mem_read  <= in_mem_read;
    end
  end

  assign out_valid     = held_valid;
  assign control       = held_control;
  assign operand0      = fwd_rs;
  assign operand1      = held_use_imm ? held_imm : fwd_rt;
  assign out_rd_addr   = held_rd_addr;
  assign out_reg_write = held_reg_write;
  assign out_mem_read  = held_mem_read;

endmodule
